// File: rtl/gp_regfile_pkg.sv
// Shared definitions for the VR16 general-purpose register file:
// clear-sweep FSM states and the default VR16 geometry.
package gp_regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int VR16_WIDTH = 16;
  localparam int VR16_DEPTH = 4;

endpackage

// File: rtl/gp_regfile_if.sv
// Write/read/clear bus between the ALU result stage, the operand-select stage
// and gp_regfile. The master drives requests; the slave is the register file.
interface gp_regfile_if #(
  parameter int WIDTH = gp_regfile_pkg::VR16_WIDTH,
  parameter int DEPTH = gp_regfile_pkg::VR16_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic [ADDR_W-1:0] read_addr_a;
  logic [ADDR_W-1:0] read_addr_b;
  logic [WIDTH-1:0]  read_data_a;
  logic [WIDTH-1:0]  read_data_b;
  logic              clear_req;
  logic              busy;
  logic              write_accept;
  logic [DEPTH-1:0]  dirty;

  modport master (
    output write_enable, write_addr, write_data, read_addr_a, read_addr_b, clear_req,
    input  read_data_a, read_data_b, busy, write_accept, dirty
  );

  modport slave (
    input  write_enable, write_addr, write_data, read_addr_a, read_addr_b, clear_req,
    output read_data_a, read_data_b, busy, write_accept, dirty
  );

endinterface

// File: rtl/gp_regfile_read_port.sv
// One registered read port: forwards a same-cycle accepted write or an
// in-progress clear, masks register 0 when it is hard-wired to zero.
module gp_read_port #(
  parameter int WIDTH   = gp_regfile_pkg::VR16_WIDTH,
  parameter int DEPTH   = gp_regfile_pkg::VR16_DEPTH,
  parameter bit R0_ZERO = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data,
  input  logic              i_wr_accept,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_clr_active,
  input  logic [ADDR_W-1:0] i_clr_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic             w_fwd_write;
  logic             w_fwd_clear;
  logic [WIDTH-1:0] w_rd_next;

  // NOTE: every signal gets its default first so no path through the block can infer a latch.
  always_comb begin
    w_fwd_write = i_wr_accept && (i_wr_addr == i_rd_addr);
    w_fwd_clear = i_clr_active && (i_clr_addr == i_rd_addr);
    w_rd_next   = i_rd_data;
    if (w_fwd_write) begin
      w_rd_next = i_wr_data;
    end else if (w_fwd_clear || (R0_ZERO && (i_rd_addr == '0))) begin
      w_rd_next = '0;
    end
  end

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= w_rd_next;
    end
  end

endmodule

// File: rtl/gp_regfile.sv
// Parametrised register file: one write port, two forwarding read ports,
// per-register dirty bits and a one-register-per-cycle hardware clear sweep.
module gp_regfile
  import gp_regfile_pkg::*;
#(
  parameter int WIDTH   = VR16_WIDTH,
  parameter int DEPTH   = VR16_DEPTH,
  parameter bit R0_ZERO = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  gp_regfile_if.slave bus
);

  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0]  r_dirty;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              w_clearing;
  logic              w_accept;

  assign w_clearing = (r_state == CLEAR);
  assign w_accept   = bus.write_enable && !w_clearing
                    && !(R0_ZERO && (bus.write_addr == '0));

  assign bus.write_accept = w_accept;
  assign bus.busy         = w_clearing;
  assign bus.dirty        = r_dirty;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // NOTE: the array is reset on purpose; its zero state is architecturally visible, so it stays in flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_dirty <= '0;
    end else if (w_clearing) begin
      r_regs[r_ptr]  <= '0;
      r_dirty[r_ptr] <= 1'b0;
    end else if (w_accept) begin
      r_regs[bus.write_addr]  <= bus.write_data;
      r_dirty[bus.write_addr] <= 1'b1;
    end
  end

  gp_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)) u_port_a (
    .clk          (clk),
    .rst          (rst),
    .i_rd_addr    (bus.read_addr_a),
    .i_rd_data    (r_regs[bus.read_addr_a]),
    .i_wr_accept  (w_accept),
    .i_wr_addr    (bus.write_addr),
    .i_wr_data    (bus.write_data),
    .i_clr_active (w_clearing),
    .i_clr_addr   (r_ptr),
    .o_rd_data    (bus.read_data_a)
  );

  gp_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)) u_port_b (
    .clk          (clk),
    .rst          (rst),
    .i_rd_addr    (bus.read_addr_b),
    .i_rd_data    (r_regs[bus.read_addr_b]),
    .i_wr_accept  (w_accept),
    .i_wr_addr    (bus.write_addr),
    .i_wr_data    (bus.write_data),
    .i_clr_active (w_clearing),
    .i_clr_addr   (r_ptr),
    .o_rd_data    (bus.read_data_b)
  );

endmodule

// File: tb/tb_gp_regfile.sv
// Bench for gp_regfile: three configurations (16x4, 16x4 with zero register,
// 32x8) driven every cycle and compared against an array-based reference model.
module tb_gp_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gp_regfile_if #(.WIDTH(16), .DEPTH(4)) if0 ();
  gp_regfile_if #(.WIDTH(16), .DEPTH(4)) if1 ();
  gp_regfile_if #(.WIDTH(32), .DEPTH(8)) if2 ();

  gp_regfile #(.WIDTH(16), .DEPTH(4), .R0_ZERO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  gp_regfile #(.WIDTH(16), .DEPTH(4), .R0_ZERO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  gp_regfile #(.WIDTH(32), .DEPTH(8), .R0_ZERO(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int total = 0;
  int bad   = 0;

  // Stimulus for the two 16x4 instances (shared) and for the 32x8 instance.
  logic        s_we, s_clr;
  logic [1:0]  s_wa, s_ra, s_rb;
  logic [15:0] s_wd;
  logic        t_we, t_clr;
  logic [2:0]  t_wa, t_ra, t_rb;
  logic [31:0] t_wd;

  // Reference model: register contents, dirty bits, next address the sweep
  // will clear (-1 when no sweep is running), expected registered read data.
  logic [31:0] m_regs  [3][8];
  logic [7:0]  m_dirty [3];
  int          m_sweep [3];
  logic [31:0] m_qa    [3];
  logic [31:0] m_qb    [3];
  int          m_depth [3] = '{4, 4, 8};
  bit          m_r0z   [3] = '{1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_accept(input int k, input bit we, input int wa);
    return we && (m_sweep[k] < 0) && !(m_r0z[k] && wa == 0);
  endfunction

  function automatic logic [31:0] m_read(input int k, input int ra, input bit we,
                                         input int wa, input logic [31:0] wd);
    if (m_accept(k, we, wa) && wa == ra) return wd;
    if (m_sweep[k] == ra) return 32'd0;
    if (m_r0z[k] && ra == 0) return 32'd0;
    return m_regs[k][ra];
  endfunction

  task automatic m_edge(input int k, input bit we, input int wa, input logic [31:0] wd, input bit clr);
    if (m_accept(k, we, wa)) begin
      m_regs[k][wa]  = wd;
      m_dirty[k][wa] = 1'b1;
    end
    if (m_sweep[k] >= 0) begin
      m_regs[k][m_sweep[k]]  = 32'd0;
      m_dirty[k][m_sweep[k]] = 1'b0;
      m_sweep[k]++;
      if (m_sweep[k] == m_depth[k]) m_sweep[k] = -1;
    end else if (clr) begin
      m_sweep[k] = 0;
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) m_regs[k][i] = 32'd0;
      m_dirty[k] = 8'd0;
      m_sweep[k] = -1;
      m_qa[k]    = 32'd0;
      m_qb[k]    = 32'd0;
    end
  endtask

  task automatic cmp_dut(input int k, input logic [31:0] qa, input logic [31:0] qb,
                         input logic busy, input logic [7:0] dirty);
    check($sformatf("dut%0d read_data_a", k), 64'(qa), 64'(m_qa[k]));
    check($sformatf("dut%0d read_data_b", k), 64'(qb), 64'(m_qb[k]));
    check($sformatf("dut%0d busy", k), 64'(busy), 64'(m_sweep[k] >= 0));
    check($sformatf("dut%0d dirty", k), 64'(dirty), 64'(m_dirty[k]));
  endtask

  task automatic check_outputs();
    cmp_dut(0, 32'(if0.read_data_a), 32'(if0.read_data_b), if0.busy, 8'(if0.dirty));
    cmp_dut(1, 32'(if1.read_data_a), 32'(if1.read_data_b), if1.busy, 8'(if1.dirty));
    cmp_dut(2, if2.read_data_a, if2.read_data_b, if2.busy, if2.dirty);
  endtask

  // One clock cycle: apply inputs, check write_accept before the edge,
  // advance the model across the edge, then check registered outputs.
  task automatic tick();
    if0.write_enable = s_we; if0.write_addr = s_wa; if0.write_data = s_wd;
    if0.read_addr_a  = s_ra; if0.read_addr_b = s_rb; if0.clear_req = s_clr;
    if1.write_enable = s_we; if1.write_addr = s_wa; if1.write_data = s_wd;
    if1.read_addr_a  = s_ra; if1.read_addr_b = s_rb; if1.clear_req = s_clr;
    if2.write_enable = t_we; if2.write_addr = t_wa; if2.write_data = t_wd;
    if2.read_addr_a  = t_ra; if2.read_addr_b = t_rb; if2.clear_req = t_clr;
    #1;
    check("dut0 write_accept", 64'(if0.write_accept), 64'(m_accept(0, s_we, s_wa)));
    check("dut1 write_accept", 64'(if1.write_accept), 64'(m_accept(1, s_we, s_wa)));
    check("dut2 write_accept", 64'(if2.write_accept), 64'(m_accept(2, t_we, t_wa)));
    for (int k = 0; k < 2; k++) begin
      m_qa[k] = m_read(k, s_ra, s_we, s_wa, 32'(s_wd));
      m_qb[k] = m_read(k, s_rb, s_we, s_wa, 32'(s_wd));
    end
    m_qa[2] = m_read(2, t_ra, t_we, t_wa, t_wd);
    m_qb[2] = m_read(2, t_rb, t_we, t_wa, t_wd);
    @(posedge clk);
    m_edge(0, s_we, s_wa, 32'(s_wd), s_clr);
    m_edge(1, s_we, s_wa, 32'(s_wd), s_clr);
    m_edge(2, t_we, t_wa, t_wd, t_clr);
    #1;
    check_outputs();
  endtask

  int n_busy;

  initial begin
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0; s_rb = '0; s_clr = 1'b0;
    t_we = 1'b0; t_wa = '0; t_wd = '0; t_ra = '0; t_rb = '0; t_clr = 1'b0;
    if0.write_enable = 1'b0; if0.write_addr = '0; if0.write_data = '0;
    if0.read_addr_a = '0; if0.read_addr_b = '0; if0.clear_req = 1'b0;
    if1.write_enable = 1'b0; if1.write_addr = '0; if1.write_data = '0;
    if1.read_addr_a = '0; if1.read_addr_b = '0; if1.clear_req = 1'b0;
    if2.write_enable = 1'b0; if2.write_addr = '0; if2.write_data = '0;
    if2.read_addr_a = '0; if2.read_addr_b = '0; if2.clear_req = 1'b0;

    // Reset state
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Write 0xBEEF to r2, read it back the next cycle
    s_we = 1'b1; s_wa = 2'd2; s_wd = 16'hBEEF; s_ra = 2'd0; s_rb = 2'd1;
    tick();
    s_we = 1'b0; s_ra = 2'd2;
    tick();
    check("beef read", 64'(if0.read_data_a), 64'h0000_BEEF);
    check("beef dirty", 64'(if0.dirty), 64'b0100);

    // Same-cycle write and read of r3 on both ports forwards the new value
    s_we = 1'b1; s_wa = 2'd3; s_wd = 16'h1234; s_ra = 2'd3; s_rb = 2'd3;
    tick();
    check("fwd port a", 64'(if0.read_data_a), 64'h1234);
    check("fwd port b", 64'(if0.read_data_b), 64'h1234);

    // Write to r0: dropped only where r0 is hard-wired to zero
    s_we = 1'b1; s_wa = 2'd0; s_wd = 16'hFFFF; s_ra = 2'd1; s_rb = 2'd1;
    tick();
    check("r0zero accept", 64'(if1.write_accept), 64'd0);
    s_we = 1'b0; s_ra = 2'd0; s_rb = 2'd3;
    tick();
    check("r0zero read", 64'(if1.read_data_a), 64'd0);
    check("r0zero dirty0", 64'(if1.dirty[0]), 64'd0);
    check("r0 normal read", 64'(if0.read_data_a), 64'hFFFF);

    // Fill r0..r3, then clear_req together with a write of 0xAAAA to r1
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1; s_wa = 2'(i); s_wd = 16'(16'h1111 * (i + 1)); s_ra = 2'(i); s_rb = 2'(3 - i);
      tick();
    end
    s_we = 1'b1; s_wa = 2'd1; s_wd = 16'hAAAA; s_clr = 1'b1; s_ra = 2'd1; s_rb = 2'd2;
    tick();
    check("clr-cycle write fwd", 64'(if0.read_data_a), 64'hAAAA);

    // Count busy cycles; mid-sweep write is refused, second clear_req ignored
    n_busy = 0;
    for (int i = 0; i < 12 && if0.busy; i++) begin
      n_busy++;
      s_we = (i == 1); s_wa = 2'd1; s_wd = 16'h5555; s_clr = (i == 2);
      s_ra = 2'd1; s_rb = 2'd3;
      tick();
      if (i == 1) check("mid-sweep accept", 64'(if0.write_accept), 64'd0);
    end
    check("busy cycles", 64'(n_busy), 64'd4);
    check("dirty after sweep", 64'(if0.dirty), 64'd0);

    // First cycle after the sweep: write accepted, everything else reads zero
    s_we = 1'b1; s_wa = 2'd3; s_wd = 16'h0F0F; s_clr = 1'b0; s_ra = 2'd0; s_rb = 2'd1;
    tick();
    check("post-sweep r0", 64'(if0.read_data_a), 64'd0);
    check("post-sweep r1", 64'(if0.read_data_b), 64'd0);
    check("post-sweep dirty", 64'(if0.dirty), 64'b1000);
    s_we = 1'b0; s_ra = 2'd2; s_rb = 2'd3;
    tick();
    check("post-sweep r2", 64'(if0.read_data_a), 64'd0);

    // 32x8: fill, start a sweep, assert reset in sweep cycle 3
    s_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t_we = 1'b1; t_wa = 3'(i); t_wd = 32'hC000_0000 | 32'(i + 1);
      tick();
    end
    t_we = 1'b0; t_clr = 1'b1; t_ra = 3'd7; t_rb = 3'd6;
    tick();
    t_clr = 1'b0;
    tick();
    tick();
    check("pre-reset busy", 64'(if2.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check("async rst busy", 64'(if2.busy), 64'd0);
    check("async rst dirty", 64'(if2.dirty), 64'd0);
    check("async rst rda", 64'(if2.read_data_a), 64'd0);
    check("async rst rdb", 64'(if2.read_data_b), 64'd0);
    check_outputs();
    rst = 1'b0;
    t_we = 1'b1; t_wa = 3'd5; t_wd = 32'hDEAD_BEEF; t_ra = 3'd5; t_rb = 3'd0;
    tick();
    check("idle after reset busy", 64'(if2.busy), 64'd0);
    check("idle after reset dirty", 64'(if2.dirty), 64'b0010_0000);

    // Randomised traffic on all three instances
    for (int n = 0; n < 400; n++) begin
      s_we  = 1'($urandom_range(0, 1));
      s_wa  = 2'($urandom_range(0, 3));
      s_wd  = 16'($urandom);
      s_ra  = 2'($urandom_range(0, 3));
      s_rb  = 2'($urandom_range(0, 3));
      s_clr = ($urandom_range(0, 15) == 0);
      t_we  = 1'($urandom_range(0, 1));
      t_wa  = 3'($urandom_range(0, 7));
      t_wd  = $urandom;
      t_ra  = 3'($urandom_range(0, 7));
      t_rb  = 3'($urandom_range(0, 7));
      t_clr = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
